shift_unit: RTL
===============

Name: shift_unit

Overview:
- Multicycle shift register unit that consumes the 3-bit shift-function code chosen by the datapath's shift-function-source mux, plus a shift amount and a data word.
- Performs load, logical/arithmetic shifts and rotates iteratively, one bit position per clock.
- Uses a start/busy/done handshake with the control unit.
- Result is held in an internal register that drives the datapath, e.g. the write-back mux for sll/srl/sra/sllv/srav.

Parameters:
- DATA_W, 32, width of the data word and result register.
- SHAMT_W, 5, width of the shift amount.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- func  input  3  shift function code from the shift-function-source mux.
- shamt  input  SHAMT_W  shift amount.
- data_in  input  DATA_W  word loaded by func=001.
- result  output  DATA_W  current content of the shift register.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle completion pulse (FIN).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: result=0, busy=0, done=0, state=IDLE, count=0. Reset mid-operation aborts immediately; no partial result is retained.
- Function codes (shift_pkg):
  - 000 NOP: register unchanged.
  - 001 LOAD: result<=data_in.
  - 010 SLL: zero fill at LSB.
  - 011 SRL: zero fill at MSB.
  - 100 SRA: MSB replicated.
  - 101 ROR.
  - 110 ROL.
  - 111 reserved: treated as NOP.
- State IDLE:
  - busy=0, done=0. start=0 means no change.
  - start=1 with func in {000,001,111}, or with a shift/rotate func and shamt=0: perform the op (LOAD writes data_in) at this edge, then go to FIN.
  - start=1 with a shift/rotate func and shamt>0: latch func and count<=shamt at this edge, then go to RUN. The register is not yet modified.
- State RUN:
  - busy=1.
  - Each edge applies one 1-bit step of the latched func to result and decrements count.
  - When count==1, the final step is applied and the FSM goes to FIN.
  - start, func, shamt and data_in are ignored; the latched copies are used.
- State FIN: done=1, busy=0 for exactly one cycle, then IDLE unconditionally. start in FIN is ignored.
- Latency, start-sample edge to done-high cycle: 1 cycle for NOP/LOAD/shamt=0; shamt+1 cycles for shifts.
- SRA sign: the current MSB is replicated at every step.
- Rotates wrap modulo DATA_W.
- Shifts with shamt up to 2^SHAMT_W-1 are legal; no saturation logic.
- result is stable in IDLE and FIN and changes only on step or load edges.

Optional Feature:
- Macro SHIFT_UNIT_BARREL_EN.
- Defined: shift/rotate with shamt>0 completes in IDLE at the start edge via a combinational barrel shifter. The FSM goes IDLE->FIN, latency is 1 cycle for all funcs, and RUN and count are unused. SRA/ROR/ROL results must be bit-identical to the iterative mode.
- Undefined: iterative behaviour as specified above.

Decomposition:
- shift_pkg holds:
  - func code localparams (FN_NOP, FN_LOAD, FN_SLL, FN_SRL, FN_SRA, FN_ROR, FN_ROL).
  - FSM state encoding (ST_IDLE, ST_RUN, ST_FIN).
  - the helper predicate is_shift(func).
- One natural sub-module: shift_step, a combinational single-bit step with inputs func and word and output the stepped word. It is reused by RUN and chained for the barrel variant, or replaced by the barrel block.

Test Plan:
- Reset then LOAD: reset_n=0 -> result=0, busy=0, done=0. start, func=001, data_in=0x8000_00F1 -> done next cycle, result=0x8000_00F1.
- SRA iterative: after the load above, start, func=100, shamt=4 -> busy for 4 cycles, done on cycle 5, result=0xF800_000F. SRL with the same inputs -> 0x0800_000F.
- Rotate wrap: result=0x0000_0001, func=101, shamt=1 -> 0x8000_0000. Then func=110, shamt=31 -> 0x4000_0000.
- Edge cases:
  - shamt=0 with SLL -> done after 1 cycle, result unchanged.
  - func=111 -> behaves as NOP.
  - start asserted during RUN with func=001 -> ignored; the final result is the shift result.
- Reset mid-op: SLL shamt=20 started, reset_n pulsed low at step 7 -> outputs are 0 asynchronously, IDLE after release. A new LOAD then works normally.
- With SHIFT_UNIT_BARREL_EN: repeat the SRA/SRL/rotate cases -> identical results, done always 1 cycle after start, busy never high.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: function codes, FSM state encoding
// and the shift/rotate classification helper.
package shift_pkg;

  localparam logic [2:0] FN_NOP  = 3'b000;
  localparam logic [2:0] FN_LOAD = 3'b001;
  localparam logic [2:0] FN_SLL  = 3'b010;
  localparam logic [2:0] FN_SRL  = 3'b011;
  localparam logic [2:0] FN_SRA  = 3'b100;
  localparam logic [2:0] FN_ROR  = 3'b101;
  localparam logic [2:0] FN_ROL  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] func);
    return (func >= FN_SLL) && (func <= FN_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of a shift/rotate function; any other code
// passes the word through unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        func,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] stepped
);

  always_comb begin
    stepped = word;
    case (func)
      FN_SLL:  stepped = {word[DATA_W-2:0], 1'b0};
      FN_SRL:  stepped = {1'b0, word[DATA_W-1:1]};
      FN_SRA:  stepped = {word[DATA_W-1], word[DATA_W-1:1]};
      FN_ROR:  stepped = {word[0], word[DATA_W-1:1]};
      FN_ROL:  stepped = {word[DATA_W-2:0], word[DATA_W-1]};
      default: stepped = word;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shift/rotate unit with start/busy/done handshake.
// Define SHIFT_UNIT_BARREL_EN to complete every shift in one cycle via a chained barrel.
//
//   state   | meaning
//   IDLE    | waiting for start; NOP/LOAD/zero-amount ops finish here
//   RUN     | one 1-bit step per clock until count reaches 1
//   FIN     | one-cycle done pulse, then back to IDLE
module shift_unit
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         func,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  result,
  output logic               busy,
  output logic               done
);

  state_t              state, state_d;
  logic [SHAMT_W-1:0]  count, count_d;
  logic [2:0]          func_q, func_d;
  logic [DATA_W-1:0]   result_q, result_d;

`ifdef SHIFT_UNIT_BARREL_EN
  localparam int N_STAGE = 1 << SHAMT_W;
  logic [DATA_W-1:0] stage [N_STAGE];
  logic [DATA_W-1:0] shift_word;

  // Chaining the same 1-bit step keeps SRA/ROR/ROL bit-identical to RUN mode.
  assign stage[0] = result_q;
  for (genvar i = 0; i < N_STAGE - 1; i++) begin : g_chain
    shift_step #(.DATA_W(DATA_W)) u_step (
      .func    (func),
      .word    (stage[i]),
      .stepped (stage[i+1])
    );
  end
  assign shift_word = stage[shamt];
`else
  logic [DATA_W-1:0] step_word;

  shift_step #(.DATA_W(DATA_W)) u_step (
    .func    (func_q),
    .word    (result_q),
    .stepped (step_word)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      func_q   <= FN_NOP;
      result_q <= '0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      func_q   <= func_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state;
    count_d  = count;
    func_d   = func_q;
    result_d = result_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_shift(func)) begin
`ifdef SHIFT_UNIT_BARREL_EN
            result_d = shift_word;
            state_d  = ST_FIN;
`else
            if (shamt == '0) begin
              state_d = ST_FIN;
            end else begin
              func_d  = func;
              count_d = shamt;
              state_d = ST_RUN;
            end
`endif
          end else begin
            // Reserved code 111 falls through as NOP.
            if (func == FN_LOAD) result_d = data_in;
            state_d = ST_FIN;
          end
        end
      end
      ST_RUN: begin
`ifdef SHIFT_UNIT_BARREL_EN
        state_d = ST_IDLE;
`else
        result_d = step_word;
        count_d  = count - SHAMT_W'(1);
        if (count == SHAMT_W'(1)) state_d = ST_FIN;
`endif
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign result = result_q;
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_FIN);

endmodule
